iter_div_unit: RTL and testbench
================================

Name: iter_div_unit

Overview:
- Parametrised multi-cycle iterative integer divider. Replaces the fixed 32-bit vendor divider IP in the execute stage.
- Supports signed and unsigned operation, configurable radix (1, 2 or 4 quotient bits per cycle), and a tag that passes through with the result.
- Uses valid/ready handshakes on both the input and output sides. Has a synchronous cancel for pipeline flushes (exceptions, ertn).
- Sits in the execute stage. The stage holds its ready_go low until out_valid.

Parameters:
WIDTH, 32, operand and result width in bits; must be even and at least 4.
SPC, 1, quotient bits retired per cycle; legal values 1, 2, 4; WIDTH % SPC == 0.
TAG_W, 5, width of the opaque tag (for example the destination register) carried alongside the operation.

Ports:
clk  in  1  clock; all state updates on the rising edge.
resetn  in  1  synchronous reset, active-low.
cancel  in  1  synchronous flush; aborts any operation in progress.
in_valid  in  1  operation request.
in_ready  out  1  unit can accept a request this cycle.
in_signed  in  1  1 = signed (div.w/mod.w), 0 = unsigned.
in_dividend  in  WIDTH  dividend.
in_divisor  in  WIDTH  divisor.
in_tag  in  TAG_W  tag, returned unchanged on out_tag.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_quotient  out  WIDTH  quotient, truncated toward zero.
out_remainder  out  WIDTH  remainder; takes the sign of the dividend.
out_div_zero  out  1  divisor was zero.
out_tag  out  TAG_W  tag of the operation.
busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, ITER, FIX, DONE.
- Reset (resetn=0 at an edge): state=IDLE. All output registers clear to 0, so out_valid=0, busy=0 and in_ready=1 on the following cycle.
- Accept: fire = in_valid && in_ready && !cancel.
- in_ready = !cancel && (IDLE || (DONE && out_ready)).
- On fire the unit latches:
  - |dividend| and |divisor| (absolute value applied only when in_signed=1);
  - the quotient sign, equal to sign(dividend) XOR sign(divisor), signed mode only;
  - the remainder sign, equal to sign(dividend);
  - the tag, and a zero-divisor flag.
- Next state after fire: ITER if the divisor is non-zero, FIX if it is zero (fast path).
- ITER:
  - Restoring division, SPC steps per cycle.
  - The partial remainder is WIDTH+1 bits wide. Each step shifts in the next dividend MSB, performs a trial subtract, and sets the quotient bit to the complement of the borrow.
  - The step counter runs from WIDTH/SPC-1 down to 0. When it reaches 0 the state moves to FIX.
- FIX: for one cycle, applies the sign fix and registers the outputs; the state then moves to DONE.
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the remainder sign is set and the remainder is non-zero.
  - On a zero divisor: quotient is all ones, remainder is the original dividend unmodified, out_div_zero=1. Signedness has no effect.
- Latency, counting the fire cycle as cycle 0: out_valid first goes high in cycle WIDTH/SPC+2 (34 for 32/1, 18 for 32/2). On the zero-divisor path it goes high in cycle 2.
- DONE:
  - out_valid=1. All outputs stay stable until out_ready=1.
  - On out_ready, the next state is IDLE, or ITER/FIX if a new fire occurs in the same cycle (back-to-back operation, no bubble).
- Signed overflow (MIN / -1): quotient=MIN, remainder=0. This falls out of the algorithm with no special case.
- cancel:
  - Takes priority over everything except reset. Any state goes to IDLE at the next edge, and out_valid is 0 in the following cycle.
  - A request presented in the cancel cycle is not accepted. in_ready is 0 in that cycle.
  - A result being offered in DONE is dropped, even if out_ready=1 in the same cycle.
- Reset mid-operation behaves identically to cancel and additionally clears the output registers.
- in_* inputs are sampled only on fire. They may change freely while busy.

Decomposition:
- Shared constants header: state encodings (IDV_IDLE, IDV_ITER, IDV_FIX, IDV_DONE) and the legal-SPC check macro.
- One sub-module, div_iter_step: purely combinational, performs SPC restoring steps.
  - Inputs: partial remainder, remaining dividend bits, divisor.
  - Outputs: next partial remainder and SPC quotient bits.
  - Instantiated once in the top level.

Test Plan:
1. Unsigned, WIDTH=32, SPC=1: 100 / 7 fired in cycle 0 → out_valid first high in cycle 34 with q=14, r=2, div_zero=0, tag echoed.
2. Signed: -7 / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / -2 → q=0xFFFFFFFD, r=1. Unsigned 0xFFFFFFF9 / 2 → q=0x7FFFFFFC, r=1.
3. Overflow: signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. The same operands unsigned → q=0, r=0x80000000.
4. Zero divisor: 0x1234 / 0, signed and unsigned → q=0xFFFFFFFF, r=0x1234, div_zero=1, out_valid in cycle 2.
5. Cancel asserted in ITER cycle 10 → IDLE next cycle, out_valid never rises, in_ready=1 the cycle after. A new op 50/5 then gives q=10, r=0. A cancel in DONE while out_ready=1 drops the result. Reset mid-ITER → all outputs 0.
6. Backpressure: out_ready held low for 5 cycles in DONE → outputs bit-stable. Then out_ready=1 with in_valid=1 in the same cycle → second op accepted back-to-back, both results correct with distinct tags. Repeat tests 1-4 with SPC=2 (latency 18) and SPC=4 (latency 10).

Source files
------------

// File: rtl/iter_div_unit_pkg.sv
// Shared constants for the iterative divider: FSM encodings and the
// parameter legality check used at elaboration time.
package iter_div_unit_pkg;

    localparam logic [1:0] IDV_IDLE = 2'd0;
    localparam logic [1:0] IDV_ITER = 2'd1;
    localparam logic [1:0] IDV_FIX  = 2'd2;
    localparam logic [1:0] IDV_DONE = 2'd3;

    function automatic bit idv_spc_legal(input int width, input int spc);
        return ((spc == 1) || (spc == 2) || (spc == 4)) &&
               ((width % spc) == 0) && (width >= 4) && ((width % 2) == 0);
    endfunction

endpackage

// File: rtl/iter_div_unit_div_iter_step.sv
// Combinational block performing SPC restoring-division steps on a
// WIDTH+1 bit partial remainder.
module div_iter_step #(
    parameter int WIDTH = 32,
    parameter int SPC   = 1
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [SPC-1:0]   q_o
);

    logic [WIDTH:0]   r;
    logic [WIDTH+1:0] diff;

    // The extra MSB of diff is the borrow of the trial subtraction.
    always_comb begin
        r    = rem_i;
        diff = '0;
        q_o  = '0;
        for (int i = 0; i < SPC; i++) begin
            r    = {r[WIDTH-1:0], dvd_i[WIDTH-1-i]};
            diff = {1'b0, r} - {2'b00, dvs_i};
            q_o[SPC-1-i] = ~diff[WIDTH+1];
            if (!diff[WIDTH+1]) begin
                r = diff[WIDTH:0];
            end
        end
        rem_o = r;
    end

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle signed/unsigned integer divider with valid/ready handshakes,
// tag pass-through and a synchronous cancel for pipeline flushes.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SPC   = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cancel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int STEPS = WIDTH / SPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);

    if (!idv_spc_legal(WIDTH, SPC)) begin : g_bad_param
        $error("iter_div_unit: illegal WIDTH/SPC combination");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] out_quo_q, out_quo_d;
    logic [WIDTH-1:0] out_rem_q, out_rem_d;
    logic             out_dz_q, out_dz_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic [WIDTH:0]   step_rem;
    logic [SPC-1:0]   step_q;
    logic             fire;
    logic             dvd_neg, dvs_neg, dvs_zero;
    logic [WIDTH-1:0] abs_dvd, abs_dvs;
    logic [WIDTH-1:0] fix_quo, fix_rem;

    div_iter_step #(
        .WIDTH (WIDTH),
        .SPC   (SPC)
    ) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign in_ready      = !cancel && ((state_q == IDV_IDLE) ||
                                       ((state_q == IDV_DONE) && out_ready));
    assign fire          = in_valid && in_ready;
    assign out_valid     = (state_q == IDV_DONE);
    assign busy          = (state_q != IDV_IDLE);
    assign out_quotient  = out_quo_q;
    assign out_remainder = out_rem_q;
    assign out_div_zero  = out_dz_q;
    assign out_tag       = out_tag_q;

    assign dvd_neg  = in_signed && in_dividend[WIDTH-1];
    assign dvs_neg  = in_signed && in_divisor[WIDTH-1];
    assign dvs_zero = (in_divisor == '0);
    assign abs_dvd  = dvd_neg ? -in_dividend : in_dividend;
    assign abs_dvs  = dvs_neg ? -in_divisor  : in_divisor;

    // After the last step dvd_q holds the quotient magnitude, rem_q the remainder.
    assign fix_quo = q_neg_q ? -dvd_q : dvd_q;
    assign fix_rem = (r_neg_q && (rem_q[WIDTH-1:0] != '0)) ? -rem_q[WIDTH-1:0]
                                                           : rem_q[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        zero_d    = zero_q;
        tag_d     = tag_q;
        out_quo_d = out_quo_q;
        out_rem_d = out_rem_q;
        out_dz_d  = out_dz_q;
        out_tag_d = out_tag_q;

        case (state_q)
            IDV_ITER: begin
                rem_d = step_rem;
                dvd_d = (dvd_q << SPC) | WIDTH'(step_q);
                if (cnt_q == '0) begin
                    state_d = IDV_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IDV_FIX: begin
                out_quo_d = zero_q ? '1 : fix_quo;
                out_rem_d = zero_q ? dvd_q : fix_rem;
                out_dz_d  = zero_q;
                out_tag_d = tag_q;
                state_d   = IDV_DONE;
            end
            IDV_DONE: begin
                if (out_ready) begin
                    state_d = IDV_IDLE;
                end
            end
            default: ;
        endcase

        // A zero divisor keeps the raw dividend so it can be returned untouched.
        if (fire) begin
            state_d = dvs_zero ? IDV_FIX : IDV_ITER;
            cnt_d   = CNT_INIT;
            rem_d   = '0;
            dvd_d   = dvs_zero ? in_dividend : abs_dvd;
            dvs_d   = abs_dvs;
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            zero_d  = dvs_zero;
            tag_d   = in_tag;
        end

        if (cancel) begin
            state_d = IDV_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            zero_q    <= 1'b0;
            tag_q     <= '0;
            out_quo_q <= '0;
            out_rem_q <= '0;
            out_dz_q  <= 1'b0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            zero_q    <= zero_d;
            tag_q     <= tag_d;
            out_quo_q <= out_quo_d;
            out_rem_q <= out_rem_d;
            out_dz_q  <= out_dz_d;
            out_tag_q <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Bench driving three divider instances (SPC = 1, 2, 4) in lockstep with a
// per-instance scoreboard for results, latency and output stability.
module tb_iter_div_unit;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic [4:0]  tag;
        int          fire_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn, cancel, in_valid, in_signed;
    logic [31:0] in_dividend, in_divisor;
    logic [4:0]  in_tag;
    logic        ordy [3];
    logic        ir [3];
    logic        ov [3];
    logic        odz [3];
    logic        bsy [3];
    logic [31:0] oq [3];
    logic [31:0] orr [3];
    logic [4:0]  otag [3];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb [3][$];
    exp_t cur;
    logic prev_ov [3];
    logic hold_v [3];
    logic [31:0] hq [3];
    logic [31:0] hr [3];
    logic [4:0]  ht [3];
    logic        hdz [3];
    vec_t tbl [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_div_unit #(.WIDTH(32), .SPC(1), .TAG_W(5)) dut_s1 (
        .clk(clk), .resetn(resetn), .cancel(cancel), .in_valid(in_valid), .in_ready(ir[0]),
        .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_quotient(oq[0]), .out_remainder(orr[0]),
        .out_div_zero(odz[0]), .out_tag(otag[0]), .busy(bsy[0]));

    iter_div_unit #(.WIDTH(32), .SPC(2), .TAG_W(5)) dut_s2 (
        .clk(clk), .resetn(resetn), .cancel(cancel), .in_valid(in_valid), .in_ready(ir[1]),
        .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_quotient(oq[1]), .out_remainder(orr[1]),
        .out_div_zero(odz[1]), .out_tag(otag[1]), .busy(bsy[1]));

    iter_div_unit #(.WIDTH(32), .SPC(4), .TAG_W(5)) dut_s4 (
        .clk(clk), .resetn(resetn), .cancel(cancel), .in_valid(in_valid), .in_ready(ir[2]),
        .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_quotient(oq[2]), .out_remainder(orr[2]),
        .out_div_zero(odz[2]), .out_tag(otag[2]), .busy(bsy[2]));

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("[TB] FAIL %s dut%0d: got 0x%h, want 0x%h", name, k, act, want);
        end
    endtask

    function automatic vec_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.sgn = sgn; v.a = a; v.b = b; v.dz = 1'b0;
        if (b == 32'd0) begin
            v.q = 32'hFFFF_FFFF; v.r = a; v.dz = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.q = 32'h8000_0000; v.r = 32'd0;
        end else if (sgn) begin
            v.q = $signed(a) / $signed(b);
            v.r = $signed(a) % $signed(b);
        end else begin
            v.q = a / b;
            v.r = a % b;
        end
        return v;
    endfunction

    // Present one request for a single cycle; all instances must be idle.
    task automatic applyStimulus(input vec_t v, input logic [4:0] tag);
        cur.q = v.q; cur.r = v.r; cur.dz = v.dz; cur.tag = tag; cur.fire_cyc = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_signed = v.sgn; in_dividend = v.a; in_divisor = v.b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_signed = 1'($urandom); in_dividend = $urandom; in_divisor = $urandom;
        in_tag = 5'($urandom);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((bsy[0] || bsy[1] || bsy[2] || sb[0].size() != 0 || sb[1].size() != 0 ||
                sb[2].size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_bad++;
            $display("[TB] FAIL idle_timeout: waited %0d cycles, limit %0d", n, budget);
        end
    endtask

    task automatic waitAllValid(input int budget);
        int n = 0;
        while (!(ov[0] && ov[1] && ov[2]) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_bad++;
            $display("[TB] FAIL valid_timeout: waited %0d cycles, limit %0d", n, budget);
        end
    endtask

    // Scoreboard: push at fire, check latency on rising valid, pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (!resetn || cancel) begin
                sb[k].delete();
                hold_v[k]  = 1'b0;
                prev_ov[k] = 1'b0;
            end else begin
                if (hold_v[k]) begin
                    checkOutput("stable_valid", k, 32'(ov[k]), 32'd1);
                    checkOutput("stable_q", k, oq[k], hq[k]);
                    checkOutput("stable_r", k, orr[k], hr[k]);
                    checkOutput("stable_tag", k, 32'(otag[k]), 32'(ht[k]));
                    checkOutput("stable_dz", k, 32'(odz[k]), 32'(hdz[k]));
                end
                if (ov[k] && !prev_ov[k]) begin
                    if (sb[k].size() == 0) begin
                        checkOutput("unexpected_valid", k, 32'(ov[k]), 32'd0);
                    end else begin
                        checkOutput("latency", k, 32'(cyc - sb[k][0].fire_cyc),
                                    sb[k][0].dz ? 32'd2 : 32'((32 >> k) + 2));
                    end
                end
                if (ov[k] && ordy[k] && sb[k].size() != 0) begin
                    e = sb[k].pop_front();
                    checkOutput("quotient", k, oq[k], e.q);
                    checkOutput("remainder", k, orr[k], e.r);
                    checkOutput("div_zero", k, 32'(odz[k]), 32'(e.dz));
                    checkOutput("tag", k, 32'(otag[k]), 32'(e.tag));
                end
                if (in_valid && ir[k]) begin
                    e = cur;
                    e.fire_cyc = cyc;
                    sb[k].push_back(e);
                end
                hold_v[k]  = ov[k] && !ordy[k];
                hq[k] = oq[k]; hr[k] = orr[k]; ht[k] = otag[k]; hdz[k] = odz[k];
                prev_ov[k] = ov[k];
            end
        end
    end

    initial begin
        vec_t v;
        tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        tbl[3]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
        tbl[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        tbl[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        tbl[6]  = '{1'b1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1};
        tbl[7]  = '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1};
        tbl[8]  = '{1'b0, 32'd50,         32'd5,          32'd10,         32'd0,          1'b0};
        tbl[9]  = '{1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        tbl[10] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        tbl[11] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};

        resetn = 1'b0; cancel = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        in_dividend = '0; in_divisor = '0; in_tag = '0;
        for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("rst_valid", k, 32'(ov[k]), 32'd0);
            checkOutput("rst_busy", k, 32'(bsy[k]), 32'd0);
            checkOutput("rst_in_ready", k, 32'(ir[k]), 32'd1);
            checkOutput("rst_q", k, oq[k], 32'd0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], 5'(i + 1));
            waitIdle(200);
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            v = model(1'(i % 3 == 0), a, b);
            applyStimulus(v, 5'(16 + i));
            waitIdle(200);
        end

        $display("[TB] cancel during ITER");
        applyStimulus(tbl[0], 5'd9);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1; in_valid = 1'b1; in_signed = 1'b0;
        in_dividend = 32'd99; in_divisor = 32'd3; in_tag = 5'd30;
        @(negedge clk);
        for (int k = 0; k < 3; k++) checkOutput("cancel_in_ready", k, 32'(ir[k]), 32'd0);
        @(posedge clk); #1;
        cancel = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("cancel_valid", k, 32'(ov[k]), 32'd0);
            checkOutput("cancel_busy", k, 32'(bsy[k]), 32'd0);
            checkOutput("cancel_in_ready_after", k, 32'(ir[k]), 32'd1);
        end
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(tbl[8], 5'd10);
        waitIdle(200);

        $display("[TB] cancel while result offered");
        for (int k = 0; k < 3; k++) ordy[k] = 1'b0;
        v = model(1'b0, 32'd1000, 32'd10);
        applyStimulus(v, 5'd12);
        waitAllValid(100);
        cancel = 1'b1;
        for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("drop_valid", k, 32'(ov[k]), 32'd0);
            checkOutput("drop_busy", k, 32'(bsy[k]), 32'd0);
        end
        waitIdle(50);

        $display("[TB] reset mid-operation");
        applyStimulus(tbl[1], 5'd13);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("rstmid_valid", k, 32'(ov[k]), 32'd0);
            checkOutput("rstmid_busy", k, 32'(bsy[k]), 32'd0);
            checkOutput("rstmid_q", k, oq[k], 32'd0);
            checkOutput("rstmid_r", k, orr[k], 32'd0);
            checkOutput("rstmid_dz", k, 32'(odz[k]), 32'd0);
            checkOutput("rstmid_tag", k, 32'(otag[k]), 32'd0);
        end
        waitIdle(50);

        $display("[TB] backpressure then back-to-back");
        for (int k = 0; k < 3; k++) ordy[k] = 1'b0;
        applyStimulus(tbl[0], 5'd20);
        waitAllValid(100);
        repeat (5) @(posedge clk);
        #1;
        cur.q = tbl[2].q; cur.r = tbl[2].r; cur.dz = tbl[2].dz; cur.tag = 5'd21; cur.fire_cyc = 0;
        in_valid = 1'b1; in_signed = tbl[2].sgn; in_dividend = tbl[2].a;
        in_divisor = tbl[2].b; in_tag = 5'd21;
        for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) checkOutput("b2b_in_ready", k, 32'(ir[k]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitIdle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
